branch_ctrl: RTL and testbench
==============================

// Module: branch_ctrl
// PURPOSE
//  Control-flow sequencer that drives the program counter. It decodes the fetched
//  instruction word and registered ALU flags, then issues init/jump_en/branch_taken/
//  branch_skip/halt/jump_addr to the PC. It consumes the PC's read_jump for a
//  consistency check. Branches are two-word: opcode word, then a 9-bit target word.
//  Also provides start/done run control, a cycle watchdog and a taken-branch counter.
// PARAMETERS
//  MAX_CYCLES  4096  watchdog limit: RUN+TARGET cycles allowed before forced halt
//  CNT_W       16    width of taken-branch counter (saturating)
// PORTS
//  CLK           in   1      clock, all state updates on posedge
//  init_n        in   1      async active-low reset
//  start         in   1      1-cycle pulse; leaves IDLE/HALTED, begins execution at PC 0
//  instr         in   9      instruction word currently fetched at PC
//  flags_in      in   3      {C,N,Z} from ALU
//  flag_we       in   1      latch flags_in into flag register at posedge
//  read_jump     in   1      from PC: current instr is a branch-target word
//  pc_init       out  1      to PC init: hold PC at 0
//  jump_en       out  1      to PC: load jump_addr
//  jump_addr     out  9      to PC: target address (= instr in TARGET)
//  branch_taken  out  1      to PC: branch condition true this cycle
//  branch_skip   out  1      to PC: branch not taken, PC += 2
//  halt          out  1      to PC: freeze PC
//  done          out  1      registered; 1 while HALTED after a HALT instr or timeout
//  timeout       out  1      sticky; watchdog expired
//  seq_err       out  1      sticky; read_jump disagreed with internal state
//  br_count      out  CNT_W  taken branches since start, saturates at all-ones
// BEHAVIOUR
//  Decode: BR = instr[8:6]==3'b110, cond = instr[5:3]; HLT = instr==9'h1FF.
//   cond: 000 always, 001 Z, 010 !Z, 011 N, 100 !N, 101 C, 110 !C, 111 never.
//   Conditions use the REGISTERED flags; a flag_we in the same cycle affects only later branches.
//  Reset (init_n=0, async): state=IDLE, flags=0, cycle_cnt=0, br_count=0,
//   done=0, timeout=0, seq_err=0. Outputs (combinational from state) are pc_init=1,
//   halt=1, and all others 0. A mid-run reset aborts immediately.
//  FSM states: IDLE, RUN, TARGET, HALTED. Outputs are Mealy on state+instr.
//  IDLE:   pc_init=1, halt=1. start -> RUN (clears cycle_cnt, br_count, done, timeout, seq_err).
//  RUN:    HLT -> halt=1, next HALTED, done<=1.
//          BR and cond true -> branch_taken=1, next TARGET, br_count+1 (saturating).
//          BR and cond false -> branch_skip=1, stay RUN.
//          Otherwise all control outputs are 0 (PC +1).
//  TARGET: jump_en=1, jump_addr=instr, next RUN. instr is not decoded in this state.
//  HALTED: halt=1. start -> clear the sticky flags and cycle_cnt, go through IDLE for one
//          cycle (pc_init=1), then RUN.
//  Latency: branch at PC=p in cycle t. Taken: PC=p+1 at t+1, PC=target at t+2.
//   Not taken: PC=p+2 at t+1.
//  Watchdog: cycle_cnt increments in RUN/TARGET. In the cycle where cycle_cnt==MAX_CYCLES-1:
//   halt=1, timeout<=1, done<=1, next HALTED. This takes priority over BR/HLT decode.
//  seq_err: read_jump=1 in RUN, or read_jump=0 in TARGET -> halt=1, seq_err<=1,
//   next HALTED, done stays 0. Priority: seq_err > watchdog > HLT > BR.
//  start while in RUN/TARGET is ignored. start is sampled only in IDLE/HALTED.
//  Only one of jump_en/branch_taken/branch_skip/halt/pc_init is high in any cycle,
//   except that pc_init and halt are both high in IDLE.
// TESTING
//  1 reset mid-TARGET, release, no start -> pc_init=1,halt=1,br_count=0, stays IDLE 10 cycles
//  2 start; Z=1 latched; instr=9'h188 (BR Z) then 9'h02A -> branch_taken t, jump_en+addr 9'h02A t+1, br_count=1
//  3 Z=0; instr=9'h188 -> branch_skip=1 one cycle, state RUN, br_count unchanged
//  4 flag_we Z=1 same cycle as BR Z with old Z=0 -> branch_skip (old flags used)
//  5 instr=9'h1FF -> halt=1, done=1 next cycle; start -> pc_init one cycle then RUN
//  6 MAX_CYCLES=8, no HLT -> halt in 8th run cycle, timeout=1, done=1; read_jump=1 in RUN -> seq_err=1

Source files
------------

// File: rtl/branch_ctrl.sv
// Control-flow sequencer: decodes branch/halt words and drives the PC's control inputs.
// It also provides start/done run control, a cycle watchdog, a read_jump consistency check and a taken-branch counter.
module branch_ctrl #(
  parameter int unsigned MAX_CYCLES = 4096,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             init_n,
  input  logic             start,
  input  logic [8:0]       instr,
  input  logic [2:0]       flags_in,
  input  logic             flag_we,
  input  logic             read_jump,
  output logic             pc_init,
  output logic             jump_en,
  output logic [8:0]       jump_addr,
  output logic             branch_taken,
  output logic             branch_skip,
  output logic             halt,
  output logic             done,
  output logic             timeout,
  output logic             seq_err,
  output logic [CNT_W-1:0] br_count
);

  localparam int unsigned CYC_W = $clog2(MAX_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_TARGET = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [2:0]       flags_q;          // {C,N,Z}
  logic [CYC_W-1:0] cycle_cnt;
  logic             restart_q;        // one-cycle IDLE pass after a restart from HALTED

  logic is_br, is_hlt, cond_true, wd_hit;
  logic clr_run, clr_halt, inc_br, set_done, set_timeout, set_seq_err;

  assign is_br  = (instr[8:6] == 3'b110);
  assign is_hlt = (instr == 9'h1FF);
  assign wd_hit = (cycle_cnt == CYC_W'(MAX_CYCLES - 1));

  // Branch condition evaluated against the registered flags only
  always_comb begin
    cond_true = 1'b0;
    case (instr[5:3])
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = flags_q[0];
      3'b010:  cond_true = !flags_q[0];
      3'b011:  cond_true = flags_q[1];
      3'b100:  cond_true = !flags_q[1];
      3'b101:  cond_true = flags_q[2];
      3'b110:  cond_true = !flags_q[2];
      default: cond_true = 1'b0;
    endcase
  end

  // Next state and Mealy PC controls; seq_err > watchdog > HLT > BR
  always_comb begin
    state_d      = state_q;
    pc_init      = 1'b0;
    jump_en      = 1'b0;
    jump_addr    = 9'd0;
    branch_taken = 1'b0;
    branch_skip  = 1'b0;
    halt         = 1'b0;
    clr_run      = 1'b0;
    clr_halt     = 1'b0;
    inc_br       = 1'b0;
    set_done     = 1'b0;
    set_timeout  = 1'b0;
    set_seq_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        pc_init = 1'b1;
        halt    = 1'b1;
        if (start || restart_q) begin
          state_d = S_RUN;
          clr_run = 1'b1;
        end
      end
      S_RUN, S_TARGET: begin
        if (read_jump != (state_q == S_TARGET)) begin
          halt        = 1'b1;
          set_seq_err = 1'b1;
          state_d     = S_HALTED;
        end else if (wd_hit) begin
          halt        = 1'b1;
          set_timeout = 1'b1;
          set_done    = 1'b1;
          state_d     = S_HALTED;
        end else if (state_q == S_TARGET) begin
          jump_en   = 1'b1;
          jump_addr = instr;
          state_d   = S_RUN;
        end else if (is_hlt) begin
          halt     = 1'b1;
          set_done = 1'b1;
          state_d  = S_HALTED;
        end else if (is_br) begin
          if (cond_true) begin
            branch_taken = 1'b1;
            inc_br       = 1'b1;
            state_d      = S_TARGET;
          end else begin
            branch_skip = 1'b1;
          end
        end
      end
      default: begin
        halt = 1'b1;
        if (start) begin
          clr_halt = 1'b1;
          state_d  = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      state_q   <= S_IDLE;
      flags_q   <= 3'd0;
      cycle_cnt <= '0;
      restart_q <= 1'b0;
      br_count  <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      restart_q <= clr_halt;
      if (flag_we) flags_q <= flags_in;
      if (clr_run || clr_halt) begin
        cycle_cnt <= '0;
        br_count  <= '0;
        done      <= 1'b0;
        timeout   <= 1'b0;
        seq_err   <= 1'b0;
      end else begin
        if (state_q == S_RUN || state_q == S_TARGET) cycle_cnt <= cycle_cnt + CYC_W'(1);
        if (inc_br && (br_count != {CNT_W{1'b1}})) br_count <= br_count + CNT_W'(1);
        if (set_done)    done    <= 1'b1;
        if (set_timeout) timeout <= 1'b1;
        if (set_seq_err) seq_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: the driver pushes expected outputs from a behavioural model,
// and a negedge monitor pops each entry and compares it with the DUT outputs.
module tb_branch_ctrl;

  localparam int MAXC  = 8;
  localparam int CNT_W = 16;

  logic             CLK;
  logic             init_n;
  logic             start;
  logic [8:0]       instr;
  logic [2:0]       flags_in;
  logic             flag_we;
  logic             read_jump;
  logic             pc_init, jump_en, branch_taken, branch_skip, halt;
  logic             done, timeout, seq_err;
  logic [8:0]       jump_addr;
  logic [CNT_W-1:0] br_count;

  branch_ctrl #(.MAX_CYCLES(MAXC), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .init_n(init_n), .start(start), .instr(instr), .flags_in(flags_in),
    .flag_we(flag_we), .read_jump(read_jump), .pc_init(pc_init), .jump_en(jump_en),
    .jump_addr(jump_addr), .branch_taken(branch_taken), .branch_skip(branch_skip),
    .halt(halt), .done(done), .timeout(timeout), .seq_err(seq_err), .br_count(br_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic             pc_init;
    logic             jump_en;
    logic [8:0]       jump_addr;
    logic             branch_taken;
    logic             branch_skip;
    logic             halt;
    logic             done;
    logic             timeout;
    logic             seq_err;
    logic [CNT_W-1:0] br_count;
  } obs_t;

  typedef struct {
    obs_t  o;
    string tag;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // Model: what the sequencer is doing (idle, running, expecting a target word, halted)
  localparam int M_IDLE = 0, M_RUN = 1, M_TGT = 2, M_HALT = 3;
  int       m_mode;
  bit       m_restart;
  logic [2:0] m_flags;
  int       m_cyc, m_br;
  bit       m_done, m_to, m_se;

  function automatic bit cond_ok(input logic [2:0] c, input logic [2:0] f);
    bit z, n, cy;
    z = f[0]; n = f[1]; cy = f[2];
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n;
      3'd4: return !n;
      3'd5: return cy;
      3'd6: return !cy;
      default: return 1'b0;
    endcase
  endfunction

  task automatic cycle(input bit rst, input bit st, input logic [8:0] ins, input bit fwe,
                       input logic [2:0] fin, input bit rj, input string tag);
    obs_t e;
    exp_t it;
    int   nxt;
    @(posedge CLK);
    #1;
    init_n = !rst; start = st; instr = ins; flag_we = fwe; flags_in = fin; read_jump = rj;
    e = '0;
    if (rst) begin
      m_mode = M_IDLE; m_restart = 0; m_flags = 3'd0; m_cyc = 0; m_br = 0;
      m_done = 0; m_to = 0; m_se = 0;
      e.pc_init = 1'b1;
      e.halt    = 1'b1;
    end else begin
      e.done = m_done; e.timeout = m_to; e.seq_err = m_se; e.br_count = CNT_W'(m_br);
      nxt = m_mode;
      if (m_mode == M_IDLE) begin
        e.pc_init = 1'b1;
        e.halt    = 1'b1;
        if (st || m_restart) begin
          nxt = M_RUN; m_cyc = 0; m_br = 0; m_done = 0; m_to = 0; m_se = 0;
        end
        m_restart = 0;
      end else if (m_mode == M_HALT) begin
        e.halt = 1'b1;
        if (st) begin
          m_se = 0; m_to = 0; m_done = 0; m_cyc = 0; m_br = 0; m_restart = 1; nxt = M_IDLE;
        end
      end else begin
        if (rj != (m_mode == M_TGT)) begin
          e.halt = 1'b1; m_se = 1; nxt = M_HALT;
        end else if (m_cyc == MAXC - 1) begin
          e.halt = 1'b1; m_to = 1; m_done = 1; nxt = M_HALT;
        end else if (m_mode == M_TGT) begin
          e.jump_en = 1'b1; e.jump_addr = ins; nxt = M_RUN;
        end else if (ins == 9'h1FF) begin
          e.halt = 1'b1; m_done = 1; nxt = M_HALT;
        end else if (ins[8:6] == 3'b110) begin
          if (cond_ok(ins[5:3], m_flags)) begin
            e.branch_taken = 1'b1; nxt = M_TGT;
            if (m_br < (1 << CNT_W) - 1) m_br++;
          end else begin
            e.branch_skip = 1'b1;
          end
        end
        m_cyc++;
      end
      if (fwe) m_flags = fin;
      m_mode = nxt;
    end
    it.o = e;
    it.tag = tag;
    sbq.push_back(it);
  endtask

  // Monitor: one comparison per cycle; jump_addr only matters while jump_en is required
  initial begin
    exp_t it;
    obs_t a;
    forever begin
      @(negedge CLK);
      if (sbq.size() > 0) begin
        it = sbq.pop_front();
        a.pc_init = pc_init; a.jump_en = jump_en; a.jump_addr = jump_addr;
        a.branch_taken = branch_taken; a.branch_skip = branch_skip; a.halt = halt;
        a.done = done; a.timeout = timeout; a.seq_err = seq_err; a.br_count = br_count;
        if (!it.o.jump_en) a.jump_addr = 9'd0;
        total++;
        if (a !== it.o) begin
          bad++;
          $display("FAIL %s t=%0t got{pi=%b je=%b ja=%h bt=%b bs=%b h=%b d=%b to=%b se=%b bc=%0d} need{pi=%b je=%b ja=%h bt=%b bs=%b h=%b d=%b to=%b se=%b bc=%0d}",
                   it.tag, $time, a.pc_init, a.jump_en, a.jump_addr, a.branch_taken, a.branch_skip,
                   a.halt, a.done, a.timeout, a.seq_err, a.br_count, it.o.pc_init, it.o.jump_en,
                   it.o.jump_addr, it.o.branch_taken, it.o.branch_skip, it.o.halt, it.o.done,
                   it.o.timeout, it.o.seq_err, it.o.br_count);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit expired");
    $fatal(1, "time limit");
  end

  initial begin
    logic [8:0] ins;
    bit         rj;
    init_n = 1'b0; start = 1'b0; instr = 9'd0; flags_in = 3'd0; flag_we = 1'b0; read_jump = 1'b0;

    cycle(1, 0, 9'h000, 0, 3'd0, 0, "reset0");
    cycle(1, 0, 9'h000, 0, 3'd0, 0, "reset1");
    // Reset in the middle of a target cycle, then no start
    cycle(0, 1, 9'h000, 0, 3'd0, 0, "start_a");
    cycle(0, 0, 9'h180, 0, 3'd0, 0, "br_always");
    cycle(1, 0, 9'h055, 0, 3'd0, 1, "rst_mid_target");
    for (int i = 0; i < 10; i++) cycle(0, 0, 9'h000, 0, 3'd0, 0, "idle_hold");
    // Taken branch on Z
    cycle(0, 1, 9'h000, 0, 3'd0, 0, "start_b");
    cycle(0, 0, 9'h000, 1, 3'b001, 0, "set_z");
    cycle(0, 0, 9'h188, 0, 3'd0, 0, "br_z_taken");
    cycle(0, 0, 9'h02A, 0, 3'd0, 1, "target_02a");
    // Not taken, and flag write in the same cycle as the branch
    cycle(0, 0, 9'h000, 1, 3'b000, 0, "clr_z");
    cycle(0, 0, 9'h188, 0, 3'd0, 0, "br_z_skip");
    cycle(0, 0, 9'h188, 1, 3'b001, 0, "br_old_flags");
    // HLT then restart through IDLE
    cycle(0, 0, 9'h1FF, 0, 3'd0, 0, "hlt");
    cycle(0, 0, 9'h000, 0, 3'd0, 0, "halted_done");
    cycle(0, 1, 9'h000, 0, 3'd0, 0, "restart");
    cycle(0, 0, 9'h000, 0, 3'd0, 0, "restart_idle");
    // Watchdog: eighth run cycle forces halt
    for (int i = 0; i < MAXC; i++) cycle(0, 0, 9'h000, 0, 3'd0, 0, "watchdog");
    cycle(0, 0, 9'h000, 0, 3'd0, 0, "timeout_halted");
    // read_jump while running
    cycle(0, 1, 9'h000, 0, 3'd0, 0, "restart2");
    cycle(0, 0, 9'h000, 0, 3'd0, 0, "restart2_idle");
    cycle(0, 0, 9'h000, 0, 3'd0, 1, "seq_err");
    cycle(0, 0, 9'h000, 0, 3'd0, 0, "seq_err_halted");

    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(19))
        0, 1, 2, 3, 4, 5, 6, 7: ins = {3'b110, 3'($urandom_range(7)), 3'($urandom_range(7))};
        8:       ins = 9'h1FF;
        default: ins = 9'($urandom_range(511));
      endcase
      rj = (m_mode == M_TGT);
      if ($urandom_range(24) == 0) rj = !rj;
      cycle(($urandom_range(199) == 0), ($urandom_range(3) == 0), ins, ($urandom_range(2) == 0),
            3'($urandom_range(7)), rj, "random");
    end

    @(posedge CLK);
    #1;
    init_n = 1'b1; start = 1'b0;
    for (int i = 0; i < 4 && sbq.size() > 0; i++) @(negedge CLK);
    #1;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d need=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
